// File: rtl/pmem_line_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pmem_arb_pkg
// Description : Shared types and default sizes for the pmem line arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package pmem_arb_pkg;

    localparam int c_line_w    = 256;
    localparam int c_burst_len = 4;
    localparam int c_beat_w    = c_line_w / c_burst_len;
    localparam int c_addr_w    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } owner_e;

    // With both caches requesting, the one that was not served last wins.
    function automatic owner_e pick_owner(input logic icache_req,
                                          input logic dcache_req,
                                          input owner_e rr_last);
        if (icache_req && dcache_req) begin
            return (rr_last == ICACHE) ? DCACHE : ICACHE;
        end else if (dcache_req) begin
            return DCACHE;
        end else begin
            return ICACHE;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmem_line_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : pmem_line_arbiter_if
// Description : Cache-pair and bursted pmem signals seen by the line arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface pmem_line_arbiter_if
    import pmem_arb_pkg::*;
#(
    parameter int LINE_W    = c_line_w,
    parameter int BURST_LEN = c_burst_len,
    parameter int ADDR_W    = c_addr_w
);
    localparam int BEAT_W = LINE_W / BURST_LEN;

    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    logic              proto_err;

    // Arbiter side
    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata, proto_err
    );

    // Cache pair plus memory side
    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata, proto_err
    );

endinterface
`default_nettype wire

// File: rtl/pmem_line_arbiter_line_beat_buf.sv
`default_nettype none
// ============================================================================
// Module      : line_beat_buf
// Description : One cache line of storage, loadable whole or one beat at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module line_beat_buf #(
    parameter int LINE_W    = 256,
    parameter int BURST_LEN = 4,
    parameter int BEAT_W    = LINE_W / BURST_LEN,
    parameter int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              load_line,
    input  wire logic [LINE_W-1:0] line_in,
    input  wire logic              load_beat,
    input  wire logic [CNT_W-1:0]  beat_idx,
    input  wire logic [BEAT_W-1:0] beat_in,
    output logic      [LINE_W-1:0] line_out,
    output logic      [BEAT_W-1:0] beat_out
);

    logic [BEAT_W-1:0] w_beats [BURST_LEN];

    for (genvar k = 0; k < BURST_LEN; k++) begin : g_beat
        logic [BEAT_W-1:0] r_beat;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_beat <= '0;
            end else if (load_line) begin
                r_beat <= line_in[k*BEAT_W +: BEAT_W];
            end else if (load_beat && (beat_idx == CNT_W'(k))) begin
                r_beat <= beat_in;
            end
        end

        assign w_beats[k] = r_beat;
    end

    always_comb begin
        line_out = '0;
        for (int k = 0; k < BURST_LEN; k++) begin
            line_out[k*BEAT_W +: BEAT_W] = w_beats[k];
        end
    end

    assign beat_out = w_beats[beat_idx];

endmodule
`default_nettype wire

// File: rtl/pmem_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pmem_line_arbiter
// Description : Round-robin sharing of one bursted pmem port by I- and D-cache.
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_line_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int LINE_W    = c_line_w,
    parameter int BURST_LEN = c_burst_len,
    parameter int ADDR_W    = c_addr_w
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pmem_line_arbiter_if.slave bus
);

    localparam int BEAT_W = LINE_W / BURST_LEN;
    localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_W / 8 - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(BURST_LEN - 1);

    state_e              r_state;
    state_e              w_next_state;
    owner_e              r_owner;
    owner_e              r_rr_last;
    owner_e              w_grant_owner;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic                r_pmem_read;
    logic                r_pmem_write;
    logic [ADDR_W-1:0]   r_pmem_addr;
    logic                r_proto_err;

    logic                w_icache_req;
    logic                w_dcache_req;
    logic                w_grant;
    logic                w_beat_done;
    logic                w_last_beat;
    logic [ADDR_W-1:0]   w_req_addr;
    logic [LINE_W-1:0]   w_line;
    logic [BEAT_W-1:0]   w_beat_rd;

    assign w_icache_req = bus.i_read;
    assign w_dcache_req = bus.d_read | bus.d_write;
    assign w_beat_done  = ((r_state == RD) || (r_state == WR)) && bus.pmem_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_grant       = 1'b0;
        w_grant_owner = ICACHE;
        w_last_beat   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_icache_req || w_dcache_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = pick_owner(w_icache_req, w_dcache_req, r_rr_last);
                    // A read+write collision from the D-cache is served as a write.
                    w_next_state  = ((w_grant_owner == DCACHE) && bus.d_write) ? WR : RD;
                end
            end
            RD, WR: begin
                if (w_beat_done && (r_beat_cnt == LAST_BEAT)) begin
                    w_last_beat  = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_req_addr = (w_grant_owner == DCACHE) ? bus.d_addr : bus.i_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= ICACHE;
            r_rr_last    <= ICACHE;
            r_beat_cnt   <= '0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_pmem_addr  <= '0;
        end else if (w_grant) begin
            r_owner      <= w_grant_owner;
            r_beat_cnt   <= '0;
            r_pmem_read  <= (w_next_state == RD);
            r_pmem_write <= (w_next_state == WR);
            r_pmem_addr  <= w_req_addr & ~OFFSET_MASK;
        end else if (w_beat_done) begin
            if (w_last_beat) begin
                // Strobes fall on the same edge that accepts the final beat.
                r_pmem_read  <= 1'b0;
                r_pmem_write <= 1'b0;
                r_rr_last    <= r_owner;
                r_beat_cnt   <= '0;
            end else begin
                r_beat_cnt   <= r_beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proto_err <= 1'b0;
        end else if (bus.d_read && bus.d_write) begin
            r_proto_err <= 1'b1;
        end
    end

    line_beat_buf #(
        .LINE_W    (LINE_W),
        .BURST_LEN (BURST_LEN),
        .BEAT_W    (BEAT_W),
        .CNT_W     (CNT_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_line (w_grant && (w_next_state == WR)),
        .line_in   (bus.d_wdata),
        .load_beat ((r_state == RD) && bus.pmem_resp),
        .beat_idx  (r_beat_cnt),
        .beat_in   (bus.pmem_rdata),
        .line_out  (w_line),
        .beat_out  (w_beat_rd)
    );

    assign bus.i_resp     = (r_state == DONE) && (r_owner == ICACHE);
    assign bus.d_resp     = (r_state == DONE) && (r_owner == DCACHE);
    assign bus.i_rdata    = w_line;
    assign bus.d_rdata    = w_line;
    assign bus.pmem_read  = r_pmem_read;
    assign bus.pmem_write = r_pmem_write;
    assign bus.pmem_addr  = r_pmem_addr;
    assign bus.pmem_wdata = w_beat_rd;
    assign bus.proto_err  = r_proto_err;

endmodule
`default_nettype wire
